tdm_demux_1x8: RTL
==================

# tdm_demux_1x8

Time-division demultiplexer: the receive-side counterpart of the team's 8:1 select mux. A serial word stream arrives one slot per valid cycle, with `sync` marking slot 0. The block tracks slot position with a 3-bit counter and steers each word into one of eight registered output lanes `y0`..`y7`. It sits at the far end of a TDM link whose transmitter scans `s2 s1 s0` from 0 to 7, and it restores the eight parallel channels.

## Interface
- `WIDTH`, default 1: bits per slot word and per output lane.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: slot word.
- `din_valid` in 1: `din`/`sync` qualified this cycle; when low, all inputs are ignored.
- `sync` in 1: marks the qualified word as slot 0; meaningful only with `din_valid`.
- `y0`..`y7` out WIDTH each: lane outputs, registered.
- `lane_vld` out 8: bit n pulses for one cycle when `yn` updates.
- `frame_done` out 1: one-cycle pulse after slot 7 is captured.
- `sync_err` out 1: one-cycle pulse on a sync violation.
- `locked` out 1: high in state LOCK.

## Operation
- Reset (`rst`=1 at an edge), which takes priority over all other inputs:
  - state HUNT, `slot_cnt`=0;
  - `y0`..`y7`=0, `lane_vld`=0, `frame_done`=0, `sync_err`=0, `locked`=0;
  - shadow registers cleared.
- Reset mid-frame discards the partial frame; no `frame_done` is produced for it.
- HUNT:
  - qualified word without `sync`: dropped; no output activity.
  - qualified word with `sync`: captured as slot 0, `slot_cnt`←1, go to LOCK.
- LOCK, per qualified word:
  - `sync`=1 and `slot_cnt`=0: normal slot 0, capture, `slot_cnt`←1.
  - `sync`=0 and `slot_cnt`≠0: normal slot, capture into lane `slot_cnt`, `slot_cnt`←`slot_cnt`+1, wrapping from 7 to 0.
  - `sync`=1 and `slot_cnt`≠0 (early sync):
    - pulse `sync_err`;
    - capture as slot 0, `slot_cnt`←1, stay in LOCK;
    - partial frame abandoned; no `frame_done`.
  - `sync`=0 and `slot_cnt`=0 (missing sync):
    - pulse `sync_err`;
    - drop the word, go to HUNT, `slot_cnt`←0.
- Capture into lane n: `yn`←`din` and `lane_vld[n]` pulses. Under `TDM_DEMUX_FRAME_LATCH_EN` the write goes to shadow register n instead; see Configuration.
- `din_valid`=0: counter and state hold; pulse outputs return to 0.
- Lanes not being written hold their value indefinitely.

## Timing
- Latency is 1 cycle: a word qualified at edge k appears on `yn`, together with `lane_vld[n]`, after edge k.
- `frame_done` is asserted in the same cycle as `lane_vld[7]`, after the edge that captured slot 7.
- `sync_err` is asserted the cycle after the offending word; on early sync it coincides with `lane_vld[0]`.
- `locked` rises the cycle after the first captured sync and falls the cycle after a missing-sync event.
- Back-to-back valid input is sustained: 8 cycles per frame, no bubbles required between frames.

## Configuration
- `TDM_DEMUX_FRAME_LATCH_EN` undefined (default): per-lane update. Each `yn` changes as its slot arrives; `lane_vld` is one-hot.
- `TDM_DEMUX_FRAME_LATCH_EN` defined: double-buffered mode.
  - Slots 0..6 write shadow registers only; no `lane_vld` pulse.
  - Capturing slot 7 copies all eight shadows, with slot 7 taken directly from `din`, to `y0`..`y7` in one edge. `lane_vld`=8'hFF and `frame_done` pulse together.
  - On early sync or missing sync, the shadow contents are abandoned and `y0`..`y7` keep the last complete frame.

## Test plan
- Reset: with `WIDTH`=4, hold `rst` for 2 cycles → all `yn`=0, `lane_vld`=0, `locked`=0; `din`=4'hF without `sync` → no change.
- Clean frame: sync+4'h0, then 4'h1..4'h7 back-to-back → after 8 edges `yn`=n, `lane_vld` walks 0x01..0x80, `frame_done` with the 0x80 pulse, `locked`=1, `sync_err`=0.
- Gaps: same frame with `din_valid` low for 3 cycles between slots 3 and 4 → identical lane values; no `lane_vld` during the gap.
- Early sync: sync at slot 5 with 4'hA → `sync_err` and `lane_vld`=0x01, `y0`=4'hA, no `frame_done`; the next 7 words fill `y1`..`y7`.
- Missing sync: a word without `sync` after slot 7 → `sync_err` pulse, `locked`→0, word dropped; the next sync relocks.
- Latch mode (macro defined): frame of 4'h8..4'hF over a prior frame of 0..7 → `y0`..`y7` stay 0..7 through slot 6, then all update to 8..F in one edge with `lane_vld`=8'hFF.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// rtl/tdm_demux_1x8.sv - 1:8 TDM demultiplexer, optional frame latch via TDM_DEMUX_FRAME_LATCH_EN
module tdm_demux_1x8 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [7:0]       lane_vld,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] slot_cnt_q, slot_cnt_d;

  // Decoded events for the current qualified word
  logic       cap;
  logic [2:0] cap_lane;
  logic       err;

  logic [WIDTH-1:0] y_q      [8];
  logic [WIDTH-1:0] y_d      [8];
  logic [WIDTH-1:0] shadow_q [8];
  logic [WIDTH-1:0] shadow_d [8];
  logic [7:0]       lane_vld_q, lane_vld_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

  // State and slot counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  // Next-state: classify each qualified word against the expected slot position
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    cap        = 1'b0;
    cap_lane   = slot_cnt_q;
    err        = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          cap        = 1'b1;
          cap_lane   = 3'd0;
          slot_cnt_d = 3'd1;
          state_d    = LOCK;
        end
      end else begin
        if (sync) begin
          // Sync always restarts the frame; anywhere but slot 0 it is an error
          cap        = 1'b1;
          cap_lane   = 3'd0;
          slot_cnt_d = 3'd1;
          err        = (slot_cnt_q != 3'd0);
        end else if (slot_cnt_q == 3'd0) begin
          // Expected sync never came: drop the word and re-acquire
          err        = 1'b1;
          state_d    = HUNT;
          slot_cnt_d = 3'd0;
        end else begin
          cap        = 1'b1;
          cap_lane   = slot_cnt_q;
          slot_cnt_d = slot_cnt_q + 3'd1;
        end
      end
    end
  end

  // Output next-values: lane writes and single-cycle status pulses
  always_comb begin
    y_d          = y_q;
    shadow_d     = shadow_q;
    lane_vld_d   = 8'h00;
    frame_done_d = 1'b0;
    sync_err_d   = err;
    if (cap) begin
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      if (cap_lane == 3'd7) begin
        // Slot 7 bypasses its shadow so the whole frame lands in one edge
        for (int n = 0; n < 7; n++) begin
          y_d[n] = shadow_q[n];
        end
        y_d[7]       = din;
        lane_vld_d   = 8'hFF;
        frame_done_d = 1'b1;
      end else begin
        shadow_d[cap_lane] = din;
      end
`else
      y_d[cap_lane]        = din;
      lane_vld_d[cap_lane] = 1'b1;
      frame_done_d         = (cap_lane == 3'd7);
`endif
    end
  end

  // Output and shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        y_q[n]      <= '0;
        shadow_q[n] <= '0;
      end
      lane_vld_q   <= 8'h00;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        y_q[n]      <= y_d[n];
        shadow_q[n] <= shadow_d[n];
      end
      lane_vld_q   <= lane_vld_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y4         = y_q[4];
  assign y5         = y_q[5];
  assign y6         = y_q[6];
  assign y7         = y_q[7];
  assign lane_vld   = lane_vld_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule
